// File: rtl/axi4lite_initiator.sv
// AXI4-Lite initiator: turns a simple core request/response port into
// single-outstanding AXI4-Lite write (AW+W+B) and read (AR+R) transactions.
// Ports:
//   aclk, aresetn                       clock, async active-low reset
//   req_valid/ready/write/addr/wdata/wstrb   core request channel
//   resp_valid/ready/rdata/err               core response channel
//   aw*/w*/b*/ar*/r*                         AXI4-Lite initiator channels
module axi4lite_initiator #(
    parameter logic [2:0] PROT  = 3'b000,
    parameter logic [3:0] CACHE = 4'b0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        awvalid,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic [3:0]  awcache,
    input  logic        awready,
    output logic        wvalid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        wready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready,
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    output logic [3:0]  arcache,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    output logic        rready
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RRESP,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        init_q;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic        aw_done, w_done;

    // init_q holds req_ready low until the first edge after reset release
    assign req_ready  = init_q && (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign wvalid  = wvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign bready  = (state_q == WRESP);
    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign rready  = (state_q == RRESP);

    // Attribute constants are forced low while reset is asserted
    assign awprot  = aresetn ? PROT  : 3'b000;
    assign arprot  = aresetn ? PROT  : 3'b000;
    assign awcache = aresetn ? CACHE : 4'b0000;
    assign arcache = aresetn ? CACHE : 4'b0000;

    // A channel is finished once its valid is gone or is being accepted now
    assign aw_done = !awvalid_q || awready;
    assign w_done  = !wvalid_q || wready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (req_write) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = READ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done)    state_d   = WRESP;
            end
            WRESP: begin
                if (bvalid) begin
                    rdata_d = 32'h0;
                    err_d   = (bresp != 2'b00);
                    state_d = RESP;
                end
            end
            READ: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RRESP;
                end
            end
            RRESP: begin
                if (rvalid) begin
                    rdata_d = rdata;
                    err_d   = (rresp != 2'b00);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            init_q    <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            init_q    <= 1'b1;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
        end
    end

endmodule
